// File: rtl/spike_gather_dispatch_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : spike_gather_dispatch_if
//  Description : Bus bundle for the spike gather engine. Groups the command
//                FIFO read port, the per-channel spike FIFO read ports and the
//                result valid/ready channel.
//                  cmd_empty/cmd_rdreq/cmd_q    : command FIFO (q valid the
//                                                 cycle after rdreq)
//                  spk_empty/spk_rdreq/spk_q    : NUM_CH spike FIFOs, channel
//                                                 i at spk_q[i*DATA_W +: DATA_W]
//                  res_valid/res_ready/res_data : result channel
//                master = gather engine, slave = FIFO / consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface spike_gather_dispatch_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int RES_W  = 36
);
  logic                     cmd_empty;
  logic                     cmd_rdreq;
  logic [31:0]              cmd_q;
  logic [NUM_CH-1:0]        spk_empty;
  logic [NUM_CH-1:0]        spk_rdreq;
  logic [NUM_CH*DATA_W-1:0] spk_q;
  logic                     res_valid;
  logic                     res_ready;
  logic [RES_W-1:0]         res_data;

  modport master (
    input  cmd_empty, cmd_q, spk_empty, spk_q, res_ready,
    output cmd_rdreq, spk_rdreq, res_valid, res_data
  );

  modport slave (
    output cmd_empty, cmd_q, spk_empty, spk_q, res_ready,
    input  cmd_rdreq, spk_rdreq, res_valid, res_data
  );
endinterface
`default_nettype wire

// File: rtl/spike_gather_dispatch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : spike_gather_dispatch
//  Description : Command-driven spike gather engine. Pops one command at a
//                time, reads the spike FIFOs selected by the command mask into
//                a per-channel buffer, and optionally emits the masked buffer
//                sum on the result channel.
//                  CLOCK_50   : clock, all logic on posedge
//                  rst        : synchronous active-high reset
//                  bus        : command / spike / result bundle (master side)
//                  busy       : FSM is not idle
//                  err_empty  : sticky, a selected channel was empty when read
//                  err_opcode : sticky, an undefined opcode was decoded
//  Revision    : 1.0  initial release
// ============================================================================
module spike_gather_dispatch #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int RES_W  = 36
) (
  input  logic                    CLOCK_50,
  input  logic                    rst,
  spike_gather_dispatch_if.master bus,
  output logic                    busy,
  output logic                    err_empty,
  output logic                    err_opcode
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [3:0]      c_op_nop    = 4'd0;
  localparam logic [3:0]      c_op_gather = 4'd1;
  localparam logic [3:0]      c_op_emit   = 4'd2;
  localparam logic [3:0]      c_op_clear  = 4'd3;
  localparam logic [3:0]      c_op_gemit  = 4'd4;
  localparam logic [CH_W-1:0] c_last_ch   = CH_W'(NUM_CH - 1);

  generate
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_num_ch_check
      $error("NUM_CH must be in 1..16");
    end
    if (RES_W < DATA_W + $clog2(NUM_CH)) begin : g_res_w_check
      $error("RES_W too narrow to hold the sum of NUM_CH words");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CMD_RD  = 4'd1,
    S_CMD_LD  = 4'd2,
    S_DECODE  = 4'd3,
    S_SPK_RD  = 4'd4,
    S_SPK_LD  = 4'd5,
    S_SUM     = 4'd6,
    S_RES_OUT = 4'd7
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_opcode;
  logic [NUM_CH-1:0] r_mask;
  logic [CH_W-1:0]   r_ch_idx;
  logic              r_rd_pend;
  logic [DATA_W-1:0] r_buf [NUM_CH];
  logic [RES_W-1:0]  r_res_data;
  logic              r_res_valid;
  logic              r_err_empty;
  logic              r_err_opcode;

  logic              w_sel;
  logic              w_sel_avail;
  logic              w_last;
  int                w_spk_base;
  logic [DATA_W-1:0] w_spk_word;
  logic [RES_W-1:0]  w_sum;
  logic              w_cmd_rdreq;
  logic [NUM_CH-1:0] w_spk_rdreq;
  logic              w_unused_cmd;

  // Only the opcode nibble and the low NUM_CH mask bits carry meaning.
  assign w_unused_cmd = ^bus.cmd_q[27:NUM_CH];

  assign w_sel       = r_mask[r_ch_idx];
  assign w_sel_avail = w_sel & ~bus.spk_empty[r_ch_idx];
  assign w_last      = (r_ch_idx == c_last_ch);
  assign w_spk_base  = int'(r_ch_idx) * DATA_W;
  assign w_spk_word  = bus.spk_q[w_spk_base +: DATA_W];

  // Zero-extended masked sum; RES_W is wide enough that it cannot overflow.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_mask[i]) w_sum = w_sum + RES_W'(r_buf[i]);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_rdreq = 1'b0;
    w_spk_rdreq = '0;
    case (r_state)
      S_IDLE:   if (!bus.cmd_empty) w_state_nxt = S_CMD_RD;
      S_CMD_RD: begin
        w_cmd_rdreq = 1'b1;
        w_state_nxt = S_CMD_LD;
      end
      S_CMD_LD: w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (r_opcode)
          c_op_emit:               w_state_nxt = S_SUM;
          c_op_gather, c_op_gemit: w_state_nxt = S_SPK_RD;
          default:                 w_state_nxt = S_IDLE;
        endcase
      end
      S_SPK_RD: begin
        // One slot per channel whether or not it is selected, so gather
        // timing does not depend on the mask.
        if (w_sel_avail) w_spk_rdreq[r_ch_idx] = 1'b1;
        w_state_nxt = S_SPK_LD;
      end
      S_SPK_LD: begin
        if (!w_last)                      w_state_nxt = S_SPK_RD;
        else if (r_opcode == c_op_gemit)  w_state_nxt = S_SUM;
        else                              w_state_nxt = S_IDLE;
      end
      S_SUM:     w_state_nxt = S_RES_OUT;
      S_RES_OUT: if (bus.res_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_opcode     <= c_op_nop;
      r_mask       <= '0;
      r_ch_idx     <= '0;
      r_rd_pend    <= 1'b0;
      r_res_data   <= '0;
      r_res_valid  <= 1'b0;
      r_err_empty  <= 1'b0;
      r_err_opcode <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_CMD_LD: begin
          r_opcode <= bus.cmd_q[31:28];
          r_mask   <= bus.cmd_q[NUM_CH-1:0];
        end
        S_DECODE: begin
          if (r_opcode == c_op_clear) begin
            for (int i = 0; i < NUM_CH; i++) r_buf[i] <= '0;
          end
          if (r_opcode == c_op_gather || r_opcode == c_op_gemit) r_ch_idx <= '0;
          if (r_opcode > c_op_gemit) r_err_opcode <= 1'b1;
        end
        S_SPK_RD: begin
          // An empty selected channel keeps its previous buffer word.
          if (w_sel_avail) r_rd_pend   <= 1'b1;
          else if (w_sel)  r_err_empty <= 1'b1;
        end
        S_SPK_LD: begin
          if (r_rd_pend) r_buf[r_ch_idx] <= w_spk_word;
          r_rd_pend <= 1'b0;
          if (!w_last) r_ch_idx <= r_ch_idx + 1'b1;
        end
        S_SUM: begin
          r_res_data  <= w_sum;
          r_res_valid <= 1'b1;
        end
        S_RES_OUT: if (bus.res_ready) r_res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.cmd_rdreq = w_cmd_rdreq;
  assign bus.spk_rdreq = w_spk_rdreq;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign busy          = (r_state != S_IDLE);
  assign err_empty     = r_err_empty;
  assign err_opcode    = r_err_opcode;

endmodule
`default_nettype wire

// File: tb/tb_spike_gather_dispatch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spike_gather_dispatch
//  Description : Directed bench for spike_gather_dispatch. Models the command
//                and spike FIFOs, keeps a queue of expected results and
//                compares each accepted result against it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spike_gather_dispatch;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int RES_W  = 36;

  logic CLOCK_50 = 1'b0;
  logic rst      = 1'b1;
  logic busy, err_empty, err_opcode;

  int checks   = 0;
  int failures = 0;
  int cmd_pulses = 0;

  logic [RES_W-1:0]  exp_q [$];
  logic [31:0]       cq [$];
  logic [DATA_W-1:0] sq [NUM_CH][$];
  logic [NUM_CH-1:0] spk_log [$];

  spike_gather_dispatch_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

  spike_gather_dispatch #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .err_empty (err_empty),
    .err_opcode(err_opcode)
  );

  initial forever #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    bus.cmd_empty = (cq.size() == 0);
    for (int ch = 0; ch < NUM_CH; ch++) bus.spk_empty[ch] = (sq[ch].size() == 0);
  endtask

  // FIFO model: pushes from the main sequence become visible shortly after
  // the negedge; reads sampled at posedge present q one cycle later.
  initial begin
    logic              c_rd;
    logic [NUM_CH-1:0] s_rd;
    bus.cmd_q = '0;
    bus.spk_q = '0;
    upd_empty();
    forever begin
      @(negedge CLOCK_50);
      #2;
      upd_empty();
      @(posedge CLOCK_50);
      c_rd = bus.cmd_rdreq;
      s_rd = bus.spk_rdreq;
      #1;
      if (c_rd && cq.size() > 0) bus.cmd_q = cq.pop_front();
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (s_rd[ch] && sq[ch].size() > 0) bus.spk_q[ch*DATA_W +: DATA_W] = sq[ch].pop_front();
      end
      upd_empty();
    end
  end

  // Monitor: read-pulse logging and result scoreboard.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      #1;
      if (bus.cmd_rdreq) cmd_pulses++;
      if (bus.spk_rdreq != '0) begin
        spk_log.push_back(bus.spk_rdreq);
        chk("spk_rdreq_onehot", 64'($onehot(bus.spk_rdreq)), 64'd1);
      end
      if (bus.res_valid && bus.res_ready) begin
        chk("sb_result_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("sb_res_data", 64'(bus.res_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_cmd(input logic [31:0] w);
    cq.push_back(w);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLOCK_50);
      done = (exp_q.size() == 0) && !busy && (cq.size() == 0) && bus.cmd_empty;
    end
    chk({tag, "_complete"}, 64'(done), 64'd1);
  endtask

  initial begin
    int  p0;
    bit  seen;
    bus.res_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_res_valid", 64'(bus.res_valid), 0);
    chk("rst_res_data", 64'(bus.res_data), 0);
    chk("rst_cmd_rdreq", 64'(bus.cmd_rdreq), 0);
    chk("rst_spk_rdreq", 64'(bus.spk_rdreq), 0);
    chk("rst_err_empty", 64'(err_empty), 0);
    chk("rst_err_opcode", 64'(err_opcode), 0);
    rst = 1'b0;
    @(negedge CLOCK_50);

    // Reset in the middle of a gather
    for (int ch = 0; ch < NUM_CH; ch++) sq[ch].push_back(DATA_W'(ch + 1));
    push_cmd(32'h1000_000F);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge CLOCK_50);
      seen = (bus.spk_rdreq != '0);
    end
    chk("t1_gather_started", 64'(seen), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    chk("t1_busy", 64'(busy), 0);
    chk("t1_res_valid", 64'(bus.res_valid), 0);
    chk("t1_cmd_rdreq", 64'(bus.cmd_rdreq), 0);
    chk("t1_spk_rdreq", 64'(bus.spk_rdreq), 0);
    rst = 1'b0;
    spk_log.delete();
    p0 = cmd_pulses;
    repeat (10) @(negedge CLOCK_50);
    chk("t1_no_spk_reads", 64'(spk_log.size()), 0);
    chk("t1_no_cmd_reads", 64'(cmd_pulses - p0), 0);
    chk("t1_idle", 64'(busy), 0);
    for (int ch = 0; ch < NUM_CH; ch++) sq[ch].delete();
    repeat (2) @(negedge CLOCK_50);

    // GATHER_EMIT all channels
    spk_log.delete();
    sq[0].push_back(32'd10); sq[1].push_back(32'd20);
    sq[2].push_back(32'd30); sq[3].push_back(32'd40);
    push_cmd(32'h4000_000F);
    exp_q.push_back(36'd100);
    wait_idle("s2", 60);
    chk("s2_rdreq_count", 64'(spk_log.size()), 64'd4);
    for (int i = 0; i < NUM_CH; i++)
      chk($sformatf("s2_rdreq_order%0d", i), 64'(spk_log[i]), 64'(4'b0001 << i));

    // EMIT ch0+ch2 with latency checks
    spk_log.delete();
    push_cmd(32'h2000_0005);
    exp_q.push_back(36'd40);
    @(negedge CLOCK_50);
    chk("s3_cmd_rdreq_lat", 64'(bus.cmd_rdreq), 64'd1);
    @(negedge CLOCK_50);
    chk("s3_cmd_rdreq_single", 64'(bus.cmd_rdreq), 0);
    repeat (2) @(negedge CLOCK_50);
    chk("s3_valid_not_yet", 64'(bus.res_valid), 0);
    @(negedge CLOCK_50);
    chk("s3_valid_rise", 64'(bus.res_valid), 64'd1);
    wait_idle("s3", 20);
    chk("s3_no_spk_reads", 64'(spk_log.size()), 0);

    // Mask 0x3 with ch1 empty; ch2 holds data but is unselected
    chk("s4_err_empty_before", 64'(err_empty), 0);
    spk_log.delete();
    sq[0].push_back(32'd5);
    sq[2].push_back(32'd99);
    push_cmd(32'h4000_0003);
    exp_q.push_back(36'd25);
    wait_idle("s4", 60);
    chk("s4_err_empty", 64'(err_empty), 64'd1);
    chk("s4_rdreq_count", 64'(spk_log.size()), 64'd1);
    chk("s4_rdreq_ch0", 64'(spk_log[0]), 64'd1);
    chk("s4_ch2_untouched", 64'(sq[2].size()), 64'd1);
    sq[2].delete();

    // Backpressure with two commands queued
    bus.res_ready = 1'b0;
    push_cmd(32'h2000_000F);
    push_cmd(32'h2000_0001);
    exp_q.push_back(36'd95);
    exp_q.push_back(36'd5);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLOCK_50);
      seen = bus.res_valid;
    end
    chk("s5_valid_rise", 64'(seen), 64'd1);
    p0 = cmd_pulses;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      chk("s5_hold_valid", 64'(bus.res_valid), 64'd1);
      chk("s5_hold_data", 64'(bus.res_data), 64'd95);
      chk("s5_hold_no_cmd", 64'(bus.cmd_rdreq), 0);
    end
    chk("s5_no_cmd_pulses", 64'(cmd_pulses - p0), 0);
    bus.res_ready = 1'b1;
    @(negedge CLOCK_50);
    chk("s5_valid_drop", 64'(bus.res_valid), 0);
    @(negedge CLOCK_50);
    chk("s5_next_cmd_read", 64'(bus.cmd_rdreq), 64'd1);
    wait_idle("s5", 40);

    // Illegal opcode, full-scale sum, clear/nop/zero-mask emits
    chk("s6_err_opcode_before", 64'(err_opcode), 0);
    push_cmd(32'h9000_0000);
    wait_idle("s6_illegal", 20);
    chk("s6_err_opcode", 64'(err_opcode), 64'd1);
    for (int ch = 0; ch < NUM_CH; ch++) sq[ch].push_back(32'hFFFF_FFFF);
    push_cmd(32'h4000_000F);
    exp_q.push_back(36'h3_FFFF_FFFC);
    wait_idle("s6_max", 60);
    push_cmd(32'h3000_0000);
    push_cmd(32'h0000_0000);
    push_cmd(32'h2000_000F);
    push_cmd(32'h2000_0000);
    exp_q.push_back(36'd0);
    exp_q.push_back(36'd0);
    wait_idle("s6_clear", 80);
    chk("s6_err_opcode_sticky", 64'(err_opcode), 64'd1);
    chk("s6_err_empty_sticky", 64'(err_empty), 64'd1);
    chk("end_scoreboard_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
